// File: rtl/arp_resolve_ctrl.sv
// arp_resolve_ctrl
//   Transmit-side sequencer for the ARP engine (gmii_rx_clk domain).
//   It answers incoming ARP requests, and it resolves a target IP to a MAC on
//   demand, with a response timeout and bounded retries. Pending replies and
//   requests share the single ARP transmit path, and replies always go first.
//
//   Optional feature: define ARP_CACHE_EN to add a one-entry resolution cache.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   resolve_req, resolve_ip          start pulse and target IP (taken when busy=0)
//   busy, resolve_done, resolve_ok   status; done is a pulse and ok is valid with it
//   resolved_mac                     MAC of the last successful resolution
//   arp_rx_done/type, src_mac/ip     received packet (type 0 = request, 1 = reply)
//   arp_tx_en/type, des_mac/ip       transmit launch pulse and its header fields
//   tx_done                          end-of-transmit pulse from the arp block
module arp_resolve_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 31_250_000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter logic [47:0] BCAST_MAC   = 48'hff_ff_ff_ff_ff_ff
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        resolve_req,
   input  logic [31:0] resolve_ip,
   output logic        busy,
   output logic        resolve_done,
   output logic        resolve_ok,
   output logic [47:0] resolved_mac,
   input  logic        arp_rx_done,
   input  logic        arp_rx_type,
   input  logic [47:0] src_mac,
   input  logic [31:0] src_ip,
   output logic        arp_tx_en,
   output logic        arp_tx_type,
   output logic [47:0] des_mac,
   output logic [31:0] des_ip,
   input  logic        tx_done
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, TX_REP, TX_REQ, WAIT_TXD} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT} rs_state_t;

   tx_state_t tx_state, tx_next;
   rs_state_t rs_state, rs_next;

   logic          rep_pend, req_pend, rsp_hit;
   logic [47:0]   rep_mac, hit_mac;
   logic [31:0]   rep_ip, tgt_ip;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry_cnt;

   logic rx_req, outstanding, match, accept, cache_hit, start;
   logic launch_rep, launch_req, req_txd, expire, success, fail, retry;

`ifdef ARP_CACHE_EN
   logic [31:0] cache_ip;
   logic        cache_vld;
   assign cache_hit = accept && cache_vld && (resolve_ip == cache_ip);
`else
   assign cache_hit = 1'b0;
`endif

   assign busy        = (rs_state != R_IDLE);
   assign rx_req      = arp_rx_done && !arp_rx_type;
   // The request counts as outstanding from its launch (req_pend clears on the
   // launch edge) until the response window closes.
   assign outstanding = (rs_state == R_SEND && !req_pend) || (rs_state == R_WAIT);
   assign match       = arp_rx_done && arp_rx_type && (src_ip == tgt_ip) && outstanding;
   assign accept      = resolve_req && !busy;
   assign start       = accept && !cache_hit;
   assign launch_rep  = (tx_state == IDLE) && rep_pend;
   assign launch_req  = (tx_state == IDLE) && !rep_pend && req_pend;
   assign req_txd     = (rs_state == R_SEND) && (tx_state == WAIT_TXD) && !arp_tx_type && tx_done;
   // A target reply arriving in the expiry cycle holds off the timeout so that
   // the registered hit turns into a success on the next cycle.
   assign expire      = (rs_state == R_WAIT) && (timer == '0) && !rsp_hit && !match;
   assign success     = (rs_state == R_WAIT) && rsp_hit;
   assign fail        = expire && (retry_cnt == RETRY_MAX);
   assign retry       = expire && (retry_cnt != RETRY_MAX);

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         IDLE:     if (rep_pend) tx_next = TX_REP;
                   else if (req_pend) tx_next = TX_REQ;
         TX_REP,
         TX_REQ:   tx_next = WAIT_TXD;
         WAIT_TXD: if (tx_done) tx_next = IDLE;
         default:  tx_next = IDLE;
      endcase
   end

   always_comb begin
      rs_next = rs_state;
      case (rs_state)
         R_IDLE:  if (start) rs_next = R_SEND;
         R_SEND:  if (req_txd) rs_next = R_WAIT;
         R_WAIT:  if (success || fail) rs_next = R_IDLE;
                  else if (retry) rs_next = R_SEND;
         default: rs_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= IDLE;
         rs_state <= R_IDLE;
      end else begin
         tx_state <= tx_next;
         rs_state <= rs_next;
      end
   end

   // Transmit outputs are loaded on the IDLE->TX_* edge so arp_tx_en is high
   // during the single TX_* cycle and des_* hold until the next launch.
   always_ff @(posedge clk) begin
      if (rst) begin
         arp_tx_en   <= 1'b0;
         arp_tx_type <= 1'b0;
         des_mac     <= '0;
         des_ip      <= '0;
         rep_pend    <= 1'b0;
         rep_mac     <= '0;
         rep_ip      <= '0;
      end else begin
         arp_tx_en <= launch_rep || launch_req;
         if (launch_rep) begin
            arp_tx_type <= 1'b1;
            des_mac     <= rep_mac;
            des_ip      <= rep_ip;
         end else if (launch_req) begin
            arp_tx_type <= 1'b0;
            des_mac     <= BCAST_MAC;
            des_ip      <= tgt_ip;
         end
         if (rx_req) begin
            rep_pend <= 1'b1;
            rep_mac  <= src_mac;
            rep_ip   <= src_ip;
         end else if (launch_rep) begin
            rep_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resolve_done <= 1'b0;
         resolve_ok   <= 1'b0;
         resolved_mac <= '0;
         req_pend     <= 1'b0;
         rsp_hit      <= 1'b0;
         hit_mac      <= '0;
         tgt_ip       <= '0;
         retry_cnt    <= '0;
         timer        <= '0;
      end else begin
         resolve_done <= success || fail || cache_hit;
         resolve_ok   <= success || cache_hit;
         if (start) begin
            tgt_ip    <= resolve_ip;
            retry_cnt <= '0;
            rsp_hit   <= 1'b0;
            req_pend  <= 1'b1;
         end else begin
            if (launch_req) req_pend <= 1'b0;
            else if (retry) req_pend <= 1'b1;
            if (match) begin
               rsp_hit <= 1'b1;
               hit_mac <= src_mac;
            end
            if (retry) retry_cnt <= retry_cnt + 1'b1;
            if (success) resolved_mac <= hit_mac;
         end
         if (req_txd) timer <= TIMER_LOAD;
         else if (rs_state == R_WAIT && timer != '0) timer <= timer - 1'b1;
      end
   end

`ifdef ARP_CACHE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_ip  <= '0;
         cache_vld <= 1'b0;
      end else if (success) begin
         cache_ip  <= tgt_ip;
         cache_vld <= 1'b1;
      end else if (fail && tgt_ip == cache_ip) begin
         cache_vld <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/arp_resolve_ctrl.md
# arp_resolve_ctrl

Sequencer for the ARP engine's transmit side, sitting between the `arp` block and its users in the `gmii_rx_clk` domain. It answers incoming ARP requests and resolves a target IP to a MAC on demand, with a response timeout and bounded retries. It arbitrates the single ARP transmit path between replies and requests, and holds a one-entry resolution cache.

## Interface
Parameters:
- `TIMEOUT_CYC`, 31_250_000: cycles to wait for an ARP reply after a request's `tx_done` (250 ms at 125 MHz).
- `MAX_RETRY`, 3: request retransmissions after the first attempt before reporting failure.
- `BCAST_MAC`, 48'hff_ff_ff_ff_ff_ff: `des_mac` used for requests.

Ports:
- `clk`, in, 1: GMII clock; all logic in this domain.
- `rst`, in, 1: synchronous, active-high reset.
- `resolve_req`, in, 1: one-cycle pulse starting a resolution; accepted only while `busy`=0, otherwise ignored.
- `resolve_ip`, in, 32: target IP, sampled with `resolve_req`.
- `busy`, out, 1: resolution in progress.
- `resolve_done`, out, 1: one-cycle pulse ending a resolution.
- `resolve_ok`, out, 1: valid with `resolve_done`; 1 means resolved, 0 means failed.
- `resolved_mac`, out, 48: MAC for the last successful resolution, held until the next success.
- `arp_rx_done`, in, 1: pulse from the ARP receiver.
- `arp_rx_type`, in, 1: 0 = request, 1 = reply.
- `src_mac`, in, 48: sender MAC of the received packet; valid with `arp_rx_done`.
- `src_ip`, in, 32: sender IP of the received packet; valid with `arp_rx_done`.
- `arp_tx_en`, out, 1: one-cycle pulse that launches an ARP transmit.
- `arp_tx_type`, out, 1: 0 = request, 1 = reply; held for the whole transmit.
- `des_mac`, out, 48: destination MAC, stable from `arp_tx_en` until `tx_done`.
- `des_ip`, out, 32: destination IP, stable from `arp_tx_en` until `tx_done`.
- `tx_done`, in, 1: pulse marking the end of an ARP transmit.

## Operation
- Reply capture: on `arp_rx_done`=1 with `arp_rx_type`=0, in any state:
  - set `rep_pend` and latch `src_mac`/`src_ip` into the reply registers;
  - a second request before service overwrites the registers, so the latest request wins.
- Response match: on `arp_rx_done`=1 with `arp_rx_type`=1 and `src_ip`=`tgt_ip`, while the request is outstanding:
  - set `rsp_hit` and latch `src_mac`;
  - the request is outstanding from `arp_tx_en` of the request through `WAIT_RSP`.
- Transmit FSM:
  - `IDLE`: if `rep_pend`, go to `TX_REP`. Else if a request is pending (`req_pend`), go to `TX_REQ`.
  - `TX_REP`: drive `arp_tx_en` for one cycle with type 1 and the latched reply MAC/IP; clear `rep_pend`; go to `WAIT_TXD`.
  - `TX_REQ`: drive `arp_tx_en` for one cycle with type 0, `des_mac`=`BCAST_MAC`, `des_ip`=`tgt_ip`; go to `WAIT_TXD`.
  - `WAIT_TXD`: wait for `tx_done`, then return to `IDLE`.
- Resolution sequencer (runs alongside the transmit FSM):
  - On an accepted `resolve_req`: latch `tgt_ip`, clear `retry_cnt` and `rsp_hit`, set `busy` and `req_pend`.
  - `req_pend` clears when `TX_REQ` issues.
  - On the request's `tx_done`, load the timer with `TIMEOUT_CYC`-1 and enter `WAIT_RSP`.
  - `WAIT_RSP`, `rsp_hit`: update `resolved_mac`, pulse `resolve_done` with `resolve_ok`=1, clear `busy`.
  - `WAIT_RSP`, timer reaches 0 and `retry_cnt`<`MAX_RETRY`: increment `retry_cnt`, set `req_pend`.
  - `WAIT_RSP`, timer reaches 0 and `retry_cnt`=`MAX_RETRY`: pulse `resolve_done` with `resolve_ok`=0.
- Priority: a pending reply always transmits before a pending request. Replies may be sent during `WAIT_RSP`, and the timer keeps running.
- Counter widths: the timer is $clog2(`TIMEOUT_CYC`) bits; `retry_cnt` is $clog2(`MAX_RETRY`+1) bits.

## Timing
- Reset values:
  - `busy`, `resolve_done`, `resolve_ok`, `arp_tx_en`, `arp_tx_type` = 0;
  - `resolved_mac`, `des_mac`, `des_ip` = 0;
  - FSM in `IDLE`; all pending flags cleared.
- Reset mid-transmit: a later `tx_done` arriving in `IDLE` is ignored.
- `resolve_req` to `busy`=1: next cycle.
- `arp_tx_en` is registered: earliest one cycle after entering `TX_*`.
- Idle case: `resolve_req` at cycle N gives `arp_tx_en` at N+2.
- `rsp_hit` to `resolve_done`: 1 cycle.
- `resolve_done` and `busy` falling occur in the same cycle.
- Response arriving in the same cycle the timer expires: the hit wins, result is success.
- `rst` overrides every other input in the same cycle.

## Configuration
- `ARP_CACHE_EN` defined:
  - keep `cache_ip` and a `cache_vld` bit, written on each success;
  - `resolve_req` with `resolve_ip`=`cache_ip` and `cache_vld`=1 pulses `resolve_done`/`resolve_ok`=1 one cycle later, with no transmit and `busy` staying 0;
  - a failed resolution for `cache_ip` clears `cache_vld`.
- `ARP_CACHE_EN` undefined: no cache logic; every `resolve_req` transmits a request.

## Test plan
- Resolve 192.168.1.102; reply from that IP with MAC 0x0A1B2C3D4E5F 100 cycles after `tx_done` -> `resolve_done`, `resolve_ok`=1, `resolved_mac`=0x0A1B2C3D4E5F, exactly one request sent.
- No reply, `TIMEOUT_CYC`=1000, `MAX_RETRY`=3 -> 4 requests 1000 cycles apart (measured from `tx_done`), then `resolve_ok`=0.
- ARP request from 192.168.1.50 during `WAIT_RSP` -> reply sent with `des_ip`=192.168.1.50 and `arp_tx_type`=1; the timer is not reset.
- Incoming request and `resolve_req` in the same cycle -> reply transmits first, then request; `des_*` stable across each transmit.
- Reply from a non-target IP, then a timer expiry coinciding with a target reply -> first ignored, second counted as success.
- With `ARP_CACHE_EN`: a second resolve of the same IP -> `resolve_done` one cycle after the request, zero transmits; after a failed resolution of that IP, the next resolve transmits.
